// File: rtl/lsu_defs.sv
// Shared definitions for the load/store unit: RISC-V funct3 width codes and FSM states.
package lsu_defs;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {
      OCIOSO    = 2'd0,
      LER       = 2'd1,
      ESCREVER  = 2'd2,
      RESPONDER = 2'd3
   } estado_t;

endpackage

// File: rtl/alinhador_dados.sv
// Combinational byte-lane logic: extracts/extends a load from a word and merges a
// sub-word store into a word. Zero latency, no flow control.
module alinhador_dados
   import lsu_defs::*;
#(
   parameter int BITS = 63
) (
   input  logic [BITS:0] palavra,
   input  logic [2:0]    deslocamento,
   input  logic [2:0]    funct3,
   input  logic [BITS:0] dado_escrita,
   output logic [BITS:0] dado_carga,
   output logic [BITS:0] palavra_mesclada
);

   localparam int W = BITS + 1;

   logic [5:0]    bits_desl;
   logic [BITS:0] deslocada;
   logic [BITS:0] mascara;

   always_comb begin
      bits_desl  = {deslocamento, 3'b000};
      deslocada  = palavra >> bits_desl;
      dado_carga = deslocada;
      case (funct3)
         F3_B:    dado_carga = {{(W-8){deslocada[7]}}, deslocada[7:0]};
         F3_H:    dado_carga = {{(W-16){deslocada[15]}}, deslocada[15:0]};
         F3_W:    dado_carga = {{(W-32){deslocada[31]}}, deslocada[31:0]};
         F3_BU:   dado_carga = {{(W-8){1'b0}}, deslocada[7:0]};
         F3_HU:   dado_carga = {{(W-16){1'b0}}, deslocada[15:0]};
         F3_WU:   dado_carga = {{(W-32){1'b0}}, deslocada[31:0]};
         default: dado_carga = deslocada;
      endcase

      // Mask covers the low size bytes; a doubleword mask is all ones, so SD replaces the whole word.
      case (funct3[1:0])
         2'd0:    mascara = {{(W-8){1'b0}}, 8'hFF};
         2'd1:    mascara = {{(W-16){1'b0}}, 16'hFFFF};
         2'd2:    mascara = {{(W-32){1'b0}}, 32'hFFFF_FFFF};
         default: mascara = '1;
      endcase
      palavra_mesclada = (palavra & ~(mascara << bits_desl))
                       | ((dado_escrita & mascara) << bits_desl);
   end

endmodule

// File: rtl/unidade_load_store.sv
// Data-memory initiator: byte-addressed loads/stores to a word RAM, RMW for sub-word stores.
// Load resp 2 cycles after accept; sub-word store 3, SD 2, error 1; pronto low while busy.
module unidade_load_store
   import lsu_defs::*;
#(
   parameter int BITS = 63
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req_valido,
   input  logic          req_escrita,
   input  logic [2:0]    req_funct3,
   input  logic [BITS:0] req_endereco,
   input  logic [BITS:0] req_dado,
   output logic          pronto,
   output logic          resp_valido,
   output logic [BITS:0] resp_dado,
   output logic          resp_erro,
   output logic [BITS:0] mem_endereco,
   output logic          mem_permisao_escrita,
   output logic [BITS:0] mem_dado_escrita,
   input  logic [BITS:0] mem_dado_leitura
);

   estado_t       estado, prox_estado;
   logic          escrita_r;
   logic [2:0]    funct3_r;
   logic [2:0]    desl_r;
   logic [BITS:0] dado_r;
   logic          erro_r;
   logic [BITS:0] palavra_lida;
   logic [BITS:0] indice_r;

   logic          aceita;
   logic          desalinhado;
   logic          ilegal;
   logic          req_erro;
   logic [BITS:0] dado_carga;
   logic [BITS:0] palavra_mesclada;

   alinhador_dados #(.BITS(BITS)) u_alinhador (
      .palavra          (palavra_lida),
      .deslocamento     (desl_r),
      .funct3           (funct3_r),
      .dado_escrita     (dado_r),
      .dado_carga       (dado_carga),
      .palavra_mesclada (palavra_mesclada)
   );

   always_comb begin
      case (req_funct3[1:0])
         2'd0:    desalinhado = 1'b0;
         2'd1:    desalinhado = req_endereco[0];
         2'd2:    desalinhado = |req_endereco[1:0];
         default: desalinhado = |req_endereco[2:0];
      endcase
      ilegal   = req_escrita ? req_funct3[2] : (req_funct3 == 3'b111);
      req_erro = desalinhado | ilegal;
      aceita   = req_valido && (estado == OCIOSO);
   end

   always_comb begin
      prox_estado          = estado;
      pronto               = 1'b0;
      resp_valido          = 1'b0;
      resp_erro            = 1'b0;
      resp_dado            = '0;
      mem_permisao_escrita = 1'b0;
      mem_dado_escrita     = '0;
      case (estado)
         OCIOSO: begin
            pronto = 1'b1;
            if (aceita) begin
               if (req_erro)
                  prox_estado = RESPONDER;
               else if (req_escrita && req_funct3 == F3_D)
                  prox_estado = ESCREVER;
               else
                  prox_estado = LER;
            end
         end
         LER: prox_estado = escrita_r ? ESCREVER : RESPONDER;
         ESCREVER: begin
            // Reset in this cycle must not leave a half-finished store in the RAM.
            mem_permisao_escrita = !reset;
            mem_dado_escrita     = palavra_mesclada;
            prox_estado          = RESPONDER;
         end
         RESPONDER: begin
            resp_valido = 1'b1;
            resp_erro   = erro_r;
            if (!erro_r && !escrita_r)
               resp_dado = dado_carga;
            prox_estado = OCIOSO;
         end
         default: prox_estado = OCIOSO;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado       <= OCIOSO;
         escrita_r    <= 1'b0;
         funct3_r     <= '0;
         desl_r       <= '0;
         dado_r       <= '0;
         erro_r       <= 1'b0;
         palavra_lida <= '0;
         indice_r     <= '0;
      end else begin
         estado <= prox_estado;
         if (aceita) begin
            escrita_r <= req_escrita;
            funct3_r  <= req_funct3;
            desl_r    <= req_endereco[2:0];
            dado_r    <= req_dado;
            erro_r    <= req_erro;
            // Rejected requests never touch the RAM, so the word index keeps its old value.
            if (!req_erro)
               indice_r <= req_endereco >> 3;
         end
         if (estado == LER)
            palavra_lida <= mem_dado_leitura;
      end
   end

   assign mem_endereco = indice_r;

endmodule

// File: tb/tb_unidade_load_store.sv
// Bench for unidade_load_store: directed scenarios then random loads/stores checked
// against a byte-addressed memory model.
module tb_unidade_load_store;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valido;
   logic        req_escrita;
   logic [2:0]  req_funct3;
   logic [63:0] req_endereco;
   logic [63:0] req_dado;
   logic        pronto;
   logic        resp_valido;
   logic [63:0] resp_dado;
   logic        resp_erro;
   logic [63:0] mem_endereco;
   logic        mem_permisao_escrita;
   logic [63:0] mem_dado_escrita;
   logic [63:0] mem_dado_leitura;

   logic [63:0] ram [16];
   logic        init_ram;
   logic [7:0]  mb [128];

   int n_pass  = 0;
   int n_total = 0;

   always #5 clock = ~clock;

   unidade_load_store #(.BITS(63)) dut (
      .clock                (clock),
      .reset                (reset),
      .req_valido           (req_valido),
      .req_escrita          (req_escrita),
      .req_funct3           (req_funct3),
      .req_endereco         (req_endereco),
      .req_dado             (req_dado),
      .pronto               (pronto),
      .resp_valido          (resp_valido),
      .resp_dado            (resp_dado),
      .resp_erro            (resp_erro),
      .mem_endereco         (mem_endereco),
      .mem_permisao_escrita (mem_permisao_escrita),
      .mem_dado_escrita     (mem_dado_escrita),
      .mem_dado_leitura     (mem_dado_leitura)
   );

   assign mem_dado_leitura = (mem_endereco < 64'd16) ? ram[mem_endereco[3:0]] : 64'd0;

   always @(posedge clock) begin
      if (init_ram) begin
         for (int i = 0; i < 16; i++) ram[i] <= 64'(i);
      end else if (mem_permisao_escrita && mem_endereco < 64'd16) begin
         ram[mem_endereco[3:0]] <= mem_dado_escrita;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [63:0] model_word(input int w);
      logic [63:0] v = 0;
      for (int b = 0; b < 8; b++) v[8*b +: 8] = mb[8*w + b];
      return v;
   endfunction

   function automatic logic model_err(input bit st, input logic [2:0] f3, input logic [63:0] a);
      int sz = 1 << f3[1:0];
      logic ill = st ? f3[2] : (f3 == 3'b111);
      return ill || ((a % 64'(sz)) != 0);
   endfunction

   function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] a);
      int sz = 1 << f3[1:0];
      logic [63:0] v = 0;
      if ((a >> 3) < 64'd16)
         for (int b = 0; b < sz; b++) v[8*b +: 8] = mb[int'(a) + b];
      if (!f3[2] && sz < 8 && v[8*sz-1])
         v = v | ~((64'd1 << (8*sz)) - 64'd1);
      return v;
   endfunction

   task automatic model_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
      int sz = 1 << f3[1:0];
      for (int b = 0; b < sz; b++) mb[int'(a) + b] = d[8*b +: 8];
   endtask

   // Watches cycles 1.. after an accept edge until resp_valido is seen.
   task automatic monitor(input bit drop, output int wcyc, output int nw, output int rcyc,
                          output logic [63:0] rdat, output logic rerr,
                          output logic [63:0] maddr1, output logic p1);
      wcyc = 0; nw = 0; rcyc = 0; rdat = 'x; rerr = 'x; maddr1 = 'x; p1 = 'x;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         if (drop) req_valido = 1'b0;
         #1;
         if (k == 1) begin
            maddr1 = mem_endereco;
            p1     = pronto;
         end
         if (mem_permisao_escrita) begin
            nw++;
            wcyc = k;
         end
         if (resp_valido) begin
            rcyc = k;
            rdat = resp_dado;
            rerr = resp_erro;
            break;
         end
      end
   endtask

   task automatic do_op(input string tag, input bit st, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] d);
      int wcyc, nw, rcyc;
      logic [63:0] rdat, maddr1;
      logic rerr, p1;
      logic e = model_err(st, f3, a);
      logic [63:0] exp_dat = (st || e) ? 64'd0 : model_load(f3, a);
      bit sd = st && (f3 == 3'b011);
      @(negedge clock);
      req_valido = 1'b1; req_escrita = st; req_funct3 = f3; req_endereco = a; req_dado = d;
      #1 chk({tag, ".pronto"}, 64'(pronto), 64'd1);
      @(posedge clock);
      monitor(1'b1, wcyc, nw, rcyc, rdat, rerr, maddr1, p1);
      chk({tag, ".busy"}, 64'(p1), 64'd0);
      chk({tag, ".lat"}, 64'(rcyc), e ? 64'd1 : (!st ? 64'd2 : (sd ? 64'd2 : 64'd3)));
      chk({tag, ".erro"}, 64'(rerr), 64'(e));
      chk({tag, ".dado"}, rdat, exp_dat);
      chk({tag, ".nwr"}, 64'(nw), (st && !e) ? 64'd1 : 64'd0);
      if (!e) chk({tag, ".addr"}, maddr1, a >> 3);
      if (st && !e) begin
         chk({tag, ".wcyc"}, 64'(wcyc), sd ? 64'd1 : 64'd2);
         model_store(f3, a, d);
         chk({tag, ".ram"}, ram[a[6:3]], model_word(int'(a >> 3)));
      end
   endtask

   initial begin
      int wcyc, nw, rcyc;
      logic [63:0] rdat, maddr1;
      logic rerr, p1;

      for (int i = 0; i < 128; i++) mb[i] = (i % 8 == 0) ? 8'(i / 8) : 8'd0;
      reset = 1'b1; init_ram = 1'b1;
      req_valido = 1'b0; req_escrita = 1'b0; req_funct3 = '0; req_endereco = '0; req_dado = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0; init_ram = 1'b0;
      #1;
      chk("rst.pronto", 64'(pronto), 64'd1);
      chk("rst.resp_valido", 64'(resp_valido), 64'd0);
      chk("rst.resp_dado", resp_dado, 64'd0);
      chk("rst.resp_erro", 64'(resp_erro), 64'd0);
      chk("rst.we", 64'(mem_permisao_escrita), 64'd0);
      chk("rst.addr", mem_endereco, 64'd0);
      chk("rst.wdata", mem_dado_escrita, 64'd0);

      do_op("ld10", 1'b0, 3'b011, 64'h10, 64'd0);
      do_op("sb13", 1'b1, 3'b000, 64'h13, 64'hAB);
      chk("sb13.word2", ram[2], 64'h0000_0000_AB00_0002);
      do_op("lb13", 1'b0, 3'b000, 64'h13, 64'd0);
      do_op("lbu13", 1'b0, 3'b100, 64'h13, 64'd0);
      do_op("sw0c", 1'b1, 3'b010, 64'h0C, 64'h8000_0001);
      chk("sw0c.word1", ram[1], 64'h8000_0001_0000_0001);
      do_op("lw0c", 1'b0, 3'b010, 64'h0C, 64'd0);
      do_op("lwu0c", 1'b0, 3'b110, 64'h0C, 64'd0);
      do_op("lh11", 1'b0, 3'b001, 64'h11, 64'd0);
      do_op("sd0c", 1'b1, 3'b011, 64'h0C, 64'h1234);
      do_op("ld111", 1'b0, 3'b111, 64'h08, 64'd0);
      do_op("sill", 1'b1, 3'b100, 64'h08, 64'h55);

      // SH abandoned by a reset pulse during the write cycle.
      @(negedge clock);
      req_valido = 1'b1; req_escrita = 1'b1; req_funct3 = 3'b001; req_endereco = 64'h18; req_dado = 64'hBEEF;
      @(posedge clock);
      @(negedge clock);
      req_valido = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      #1 chk("rstw.we", 64'(mem_permisao_escrita), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rstw.pronto", 64'(pronto), 64'd1);
      chk("rstw.resp", 64'(resp_valido), 64'd0);
      @(negedge clock);
      #1 chk("rstw.resp2", 64'(resp_valido), 64'd0);
      chk("rstw.word3", ram[3], 64'h3);

      // SD with req_valido held and a second request waiting behind it.
      @(negedge clock);
      req_valido = 1'b1; req_escrita = 1'b1; req_funct3 = 3'b011; req_endereco = 64'h20;
      req_dado = 64'hDEAD_BEEF_CAFE_F00D;
      @(posedge clock);
      #1 req_escrita = 1'b0; req_dado = 64'd0;
      monitor(1'b0, wcyc, nw, rcyc, rdat, rerr, maddr1, p1);
      chk("hold.wcyc", 64'(wcyc), 64'd1);
      chk("hold.nwr", 64'(nw), 64'd1);
      chk("hold.lat", 64'(rcyc), 64'd2);
      chk("hold.busy", 64'(p1), 64'd0);
      model_store(3'b011, 64'h20, 64'hDEAD_BEEF_CAFE_F00D);
      @(negedge clock);
      #1 chk("hold.pronto3", 64'(pronto), 64'd1);
      @(posedge clock);
      monitor(1'b1, wcyc, nw, rcyc, rdat, rerr, maddr1, p1);
      chk("hold2.lat", 64'(rcyc), 64'd2);
      chk("hold2.dado", rdat, 64'hDEAD_BEEF_CAFE_F00D);
      chk("hold2.erro", 64'(rerr), 64'd0);
      chk("hold2.nwr", 64'(nw), 64'd0);

      do_op("ldoor", 1'b0, 3'b011, 64'h400, 64'd0);

      for (int n = 0; n < 60; n++) begin
         bit          st = 1'($urandom_range(0, 1));
         logic [2:0]  f3 = 3'($urandom_range(0, 7));
         logic [63:0] a  = 64'($urandom_range(0, 127));
         logic [63:0] d  = {$urandom, $urandom};
         do_op("rnd", st, f3, a, d);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/unidade_load_store.md
Name: unidade_load_store

Overview:
Initiator side of the data-memory interface. Accepts byte-addressed load/store requests from the core datapath and translates them into word-indexed accesses on the data RAM (combinational read, write at posedge when write-enable is high). Handles sub-word stores by read-modify-write and sub-word loads by extraction with sign or zero extension. Sits between the core's execute stage and the data RAM.

Parameters:
BITS, 63, MSB index of data/address buses (bus width = BITS+1 = 64).

Ports:
clock  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
req_valido  in  1  core request valid.
req_escrita  in  1  1 = store, 0 = load.
req_funct3  in  3  RISC-V funct3: load 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; store 000 SB, 001 SH, 010 SW, 011 SD.
req_endereco  in  BITS+1  byte address.
req_dado  in  BITS+1  store data, right-aligned.
pronto  out  1  high only in OCIOSO; request accepted on posedge with req_valido && pronto.
resp_valido  out  1  one-cycle completion pulse.
resp_dado  out  BITS+1  load result, extended; 0 for stores and errors.
resp_erro  out  1  qualified by resp_valido: misaligned or illegal funct3.
mem_endereco  out  BITS+1  word index = latched byte address >> 3.
mem_permisao_escrita  out  1  RAM write enable.
mem_dado_escrita  out  BITS+1  merged write word.
mem_dado_leitura  in  BITS+1  RAM read data, combinational from mem_endereco.

Behaviour:
- Reset values: state OCIOSO; pronto=1, resp_valido=0, resp_dado=0, resp_erro=0, mem_permisao_escrita=0, mem_endereco=0, mem_dado_escrita=0; request latches cleared.
- On accept: latch req_escrita, req_funct3, req_endereco, req_dado; inputs ignored until back in OCIOSO.
- Alignment: size from funct3[1:0] (1/2/4/8 bytes); misaligned when the address low bits are not a multiple of the size. Illegal funct3: load 111; store with funct3[2]=1.
- States: OCIOSO, LER, ESCREVER, RESPONDER.
- OCIOSO -> RESPONDER if error (resp_erro=1; no RAM access, mem_permisao_escrita never asserted); -> ESCREVER if SD; else -> LER.
- LER: mem_endereco driven; register mem_dado_leitura into palavra_lida. Load -> RESPONDER. Sub-word store -> ESCREVER.
- ESCREVER: mem_permisao_escrita=1 for exactly one cycle. mem_dado_escrita = palavra_lida with bytes [off .. off+size-1] (off = addr[2:0], little-endian, byte 0 = bits 7:0) replaced by the low size bytes of req_dado; SD writes req_dado whole. -> RESPONDER.
- RESPONDER: resp_valido=1 for one cycle; -> OCIOSO.
- Load extraction: shift palavra_lida right by 8*off, take the low size bytes. Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU; LD is passed through unchanged.
- Latency (accept edge = cycle 0): load resp_valido in cycle 2; sub-word store write in cycle 2, resp in cycle 3; SD write in cycle 1, resp in cycle 2; error resp in cycle 1.
- mem_permisao_escrita is gated with !reset: reset asserted during ESCREVER suppresses the write. Reset in any state abandons the operation, with no resp_valido.
- mem_endereco holds its last value outside LER/ESCREVER; the RAM returns 0 for out-of-range indices, and the unit passes that through without error.
- Back-to-back: a new request is accepted in the cycle after RESPONDER (pronto re-asserts then).

Decomposition:
- Shared package (lsu_defs): funct3 localparams (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU) and state encodings (2-bit).
- One sub-module: alinhador_dados. Combinational; given word, offset, funct3 and store data, produces the extracted/extended load value and the merged store word. Keeps the FSM file free of byte lanes.

Test Plan:
1. RAM word 2 = 0x0000_0000_0000_0002; LD addr 0x10 -> resp_valido in cycle 2, resp_dado=0x2, resp_erro=0, mem_endereco=2.
2. SB addr 0x13 data 0xAB over word 2 = 0x2 -> one write pulse in cycle 2, word 2 = 0x0000_0000_AB00_0002; then LB 0x13 -> 0xFFFF_FFFF_FFFF_FFAB, LBU 0x13 -> 0xAB.
3. SW addr 0x0C data 0x8000_0001 over word 1 = 0x1 -> word 1 = 0x8000_0001_0000_0001; LW 0x0C -> 0xFFFF_FFFF_8000_0001, LWU 0x0C -> 0x8000_0001.
4. LH addr 0x11, SD addr 0x0C, load funct3=111 -> resp_valido in cycle 1, resp_erro=1, resp_dado=0, mem_permisao_escrita never high.
5. SH addr 0x18 with reset pulsed in the ESCREVER cycle -> no write (word 3 still 0x3), no resp_valido, pronto=1 the cycle after.
6. SD addr 0x20 data 0xDEAD_BEEF_CAFE_F00D while req_valido is held high with a second request -> write in cycle 1, resp in cycle 2, second request accepted only in cycle 3; LD 0x20 returns 0xDEAD_BEEF_CAFE_F00D.
